// File: rtl/i2c_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : i2c_pkg                                                       |
// | Brief    : Opcodes and FSM states shared by the byte master & sequencer  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package i2c_pkg;

   localparam logic [2:0] c_op_start     = 3'd1;
   localparam logic [2:0] c_op_stop      = 3'd2;
   localparam logic [2:0] c_op_write     = 3'd3;
   localparam logic [2:0] c_op_read_ack  = 3'd4;
   localparam logic [2:0] c_op_read_nack = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_STOP  = 3'd2,
      ST_WRITE = 3'd3,
      ST_READ  = 3'd4,
      ST_DONE  = 3'd5
   } i2c_state_e;

   function automatic logic op_legal(input logic [2:0] op);
      return (op >= c_op_start) && (op <= c_op_read_nack);
   endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_qtr_tick.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : i2c_qtr_tick                                                  |
// | Brief    : Quarter-bit divider; held at zero whenever run is low         |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module i2c_qtr_tick #(
   parameter int CLK_DIV = 30
) (
   input  logic clk,
   input  logic nReset,
   input  logic run,
   output logic tick
);

   localparam int c_cw = $clog2(CLK_DIV);

   logic [c_cw-1:0] cnt_q, cnt_d;

   assign tick = run && (cnt_q == c_cw'(CLK_DIV - 1));

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (!run || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!nReset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/i2c_byte_master.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : i2c_byte_master                                               |
// | Brief    : Command-driven I2C master: START/STOP/WRITE/READ one byte.    |
// |            Define I2C_CLK_STRETCH_EN to honour slave clock stretching.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module i2c_byte_master #(
   parameter int CLK_DIV = 30
) (
   input  logic       clk,
   input  logic       nReset,
   input  logic       cmd_valid,
   input  logic [2:0] cmd,
   input  logic [7:0] wdata,
   output logic       cmd_ready,
   output logic       rsp_valid,
   output logic [7:0] rdata,
   output logic       ack_rx,
   output logic       err,
   output logic       scl_oe,
   output logic       sda_oe,
   input  logic       scl_in,
   input  logic       sda_in
);
   import i2c_pkg::*;

   i2c_state_e state_q, state_d;
   logic [1:0] qtr_q, qtr_d;
   logic [3:0] bit_q, bit_d;
   logic [2:0] op_q, op_d;
   logic [7:0] shreg_q, shreg_d;
   logic [7:0] rdata_q, rdata_d;
   logic       ninth_q, ninth_d;
   logic       ack_q, ack_d;
   logic       err_q, err_d;
   logic       scl_oe_q, scl_oe_d;
   logic       sda_oe_q, sda_oe_d;
   logic       w_busy, w_data, w_last, w_run, w_tick;

   assign w_busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign w_data = (state_q == ST_WRITE) || (state_q == ST_READ);
   assign w_last = !w_data || (bit_q == 4'd8);

`ifdef I2C_CLK_STRETCH_EN
   // Holding the divider in reset while SCL is low restarts the Q1 count once SCL rises
   assign w_run = w_busy && !((qtr_q == 2'd1) && !scl_in);
`else
   logic w_unused_scl;
   assign w_unused_scl = scl_in;
   assign w_run        = w_busy;
`endif

   i2c_qtr_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_qtr_tick (
      .clk    (clk),
      .nReset (nReset),
      .run    (w_run),
      .tick   (w_tick)
   );

   always_ff @(posedge clk) begin
      if (!nReset) begin
         state_q  <= ST_IDLE;
         qtr_q    <= 2'd0;
         bit_q    <= 4'd0;
         op_q     <= 3'd0;
         shreg_q  <= 8'd0;
         rdata_q  <= 8'd0;
         ninth_q  <= 1'b0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         scl_oe_q <= 1'b0;
         sda_oe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         qtr_q    <= qtr_d;
         bit_q    <= bit_d;
         op_q     <= op_d;
         shreg_q  <= shreg_d;
         rdata_q  <= rdata_d;
         ninth_q  <= ninth_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         scl_oe_q <= scl_oe_d;
         sda_oe_q <= sda_oe_d;
      end
   end

   always_comb begin
      state_d = state_q;
      qtr_d   = qtr_q;
      bit_d   = bit_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               qtr_d = 2'd0;
               bit_d = 4'd0;
               case (cmd)
                  c_op_start:                    state_d = ST_START;
                  c_op_stop:                     state_d = ST_STOP;
                  c_op_write:                    state_d = ST_WRITE;
                  c_op_read_ack, c_op_read_nack: state_d = ST_READ;
                  default:                       state_d = ST_DONE;
               endcase
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: begin
            if (w_tick) begin
               qtr_d = qtr_q + 2'd1;
               if (qtr_q == 2'd3) begin
                  bit_d = bit_q + 4'd1;
                  if (w_last) begin
                     state_d = ST_DONE;
                  end
               end
            end
         end
      endcase
   end

   // Line actions are applied on the tick that enters each quarter
   always_comb begin
      op_d     = op_q;
      shreg_d  = shreg_q;
      rdata_d  = rdata_q;
      ninth_d  = ninth_q;
      ack_d    = ack_q;
      err_d    = err_q;
      scl_oe_d = scl_oe_q;
      sda_oe_d = sda_oe_q;
      if (state_q == ST_IDLE) begin
         if (cmd_valid) begin
            op_d    = cmd;
            shreg_d = wdata;
            err_d   = !op_legal(cmd);
            case (cmd)
               c_op_start:                    sda_oe_d = 1'b0;
               c_op_stop:                     sda_oe_d = 1'b1;
               c_op_write:                    sda_oe_d = ~wdata[7];
               c_op_read_ack, c_op_read_nack: sda_oe_d = 1'b0;
               default:                       sda_oe_d = sda_oe_q;
            endcase
         end
      end else if (w_busy && w_tick) begin
         case (qtr_q)
            2'd0: scl_oe_d = 1'b0;
            2'd1: begin
               if (state_q == ST_START) begin
                  sda_oe_d = 1'b1;
               end else if (state_q == ST_STOP) begin
                  sda_oe_d = 1'b0;
               end
            end
            2'd2: begin
               if (state_q != ST_STOP) begin
                  scl_oe_d = 1'b1;
               end
               if (w_data) begin
                  if (bit_q == 4'd8) begin
                     ninth_d = sda_in;
                  end else begin
                     shreg_d = {shreg_q[6:0], sda_in};
                  end
               end
            end
            default: begin
               if (w_data) begin
                  if (bit_q == 4'd8) begin
                     if (state_q == ST_WRITE) begin
                        ack_d = ~ninth_q;
                     end else begin
                        rdata_d = shreg_q;
                     end
                  end else if (bit_q == 4'd7) begin
                     sda_oe_d = (state_q == ST_READ) && (op_q == c_op_read_ack);
                  end else begin
                     sda_oe_d = (state_q == ST_WRITE) && ~shreg_q[7];
                  end
               end
            end
         endcase
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_DONE);
   assign err       = err_q && rsp_valid;
   assign rdata     = rdata_q;
   assign ack_rx    = ack_q;
   assign scl_oe    = scl_oe_q;
   assign sda_oe    = sda_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_byte_master.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_i2c_byte_master                                            |
// | Brief    : Directed bench for i2c_byte_master with a bit-level slave     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_i2c_byte_master;
   import i2c_pkg::*;

   localparam int CLK_DIV   = 4;
   localparam int LAT_SHORT = 4 * CLK_DIV + 1;
   localparam int LAT_BYTE  = 36 * CLK_DIV + 1;
`ifdef I2C_CLK_STRETCH_EN
   localparam int STRETCH_EXTRA = 50;
`else
   localparam int STRETCH_EXTRA = 0;
`endif

   logic       clk = 1'b0;
   logic       nReset = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [2:0] cmd = 3'd0;
   logic [7:0] wdata = 8'd0;
   logic       cmd_ready, rsp_valid, ack_rx, err, scl_oe, sda_oe;
   logic [7:0] rdata;
   wire        scl_in, sda_in;

   logic       sl_hold = 1'b0;
   int         sl_mode = 0;
   logic [7:0] sl_byte = 8'd0;
   logic       sl_ack = 1'b0;
   int         fall_base = 0;
   logic       sl_drv;
   int         rel;

   int          fall_total = 0, rise_total = 0, start_seen = 0, stop_seen = 0;
   logic [15:0] rx_bits = 16'd0;
   logic        prev_scl = 1'b1, prev_sda = 1'b1;

   int   n_checks = 0, n_errors = 0;
   int   lat, s0, r0, pulses;
   logic e_seen, scl_keep, sda_keep;

   wire scl_line = ~scl_oe & ~sl_hold;
   wire sda_line = ~sda_oe & ~sl_drv;
   assign scl_in = scl_line;
   assign sda_in = sda_line;

   i2c_byte_master #(.CLK_DIV(CLK_DIV)) dut (
      .clk       (clk),
      .nReset    (nReset),
      .cmd_valid (cmd_valid),
      .cmd       (cmd),
      .wdata     (wdata),
      .cmd_ready (cmd_ready),
      .rsp_valid (rsp_valid),
      .rdata     (rdata),
      .ack_rx    (ack_rx),
      .err       (err),
      .scl_oe    (scl_oe),
      .sda_oe    (sda_oe),
      .scl_in    (scl_in),
      .sda_in    (sda_in)
   );

   always #5 clk = ~clk;

   // Slave: mode 1 ACKs after 8 SCL falls, mode 2 shifts sl_byte out MSB first
   always_comb begin
      rel    = fall_total - fall_base;
      sl_drv = 1'b0;
      if (sl_mode == 1) begin
         sl_drv = (rel == 8) && sl_ack;
      end else if (sl_mode == 2 && rel >= 0 && rel < 8) begin
         sl_drv = !sl_byte[3'(7 - rel)];
      end
   end

   always @(negedge clk) begin
      if (!prev_scl && scl_line) begin
         rx_bits    <= {rx_bits[14:0], sda_line};
         rise_total <= rise_total + 1;
      end
      if (prev_scl && !scl_line) fall_total <= fall_total + 1;
      if (prev_scl && scl_line && prev_sda && !sda_line) start_seen <= start_seen + 1;
      if (prev_scl && scl_line && !prev_sda && sda_line) stop_seen <= stop_seen + 1;
      prev_scl <= scl_line;
      prev_sda <= sda_line;
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic run_cmd(input logic [2:0] op, input logic [7:0] wd, input int mode,
                          input bit stretch, input bit poke, output int l, output logic e);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd       = op;
      wdata     = wd;
      fall_base = fall_total;
      sl_mode   = mode;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd       = 3'd0;
      wdata     = ~wd;
      l = 1;
      while (!rsp_valid && l < 2000) begin
         if (stretch && l == 4)  sl_hold = 1'b1;
         if (stretch && l == 55) sl_hold = 1'b0;
         if (poke && l == 20) begin
            cmd_valid = 1'b1;
            cmd       = c_op_stop;
            check_eq("busy_not_ready", {31'd0, cmd_ready}, 32'd0);
         end
         if (poke && l == 21) begin
            cmd_valid = 1'b0;
            cmd       = 3'd0;
         end
         @(negedge clk);
         l++;
      end
      e = err;
      if (!rsp_valid) $display("FAIL rsp_timeout: got no rsp_valid expected one within 2000 cycles");
      @(negedge clk);
      check_eq("rsp_one_cycle", {30'd0, rsp_valid, cmd_ready}, 32'd1);
   endtask

   initial begin
      nReset = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
      check_eq("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
      check_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);
      check_eq("rst_rsp", {31'd0, rsp_valid}, 32'd0);
      check_eq("rst_err", {31'd0, err}, 32'd0);
      check_eq("rst_rdata", {24'd0, rdata}, 32'd0);
      check_eq("rst_ack", {31'd0, ack_rx}, 32'd0);
      nReset = 1'b1;

      s0 = start_seen;
      run_cmd(c_op_start, 8'h00, 0, 1'b0, 1'b0, lat, e_seen);
      check_eq("start_lat", lat, LAT_SHORT);
      check_eq("start_err", {31'd0, e_seen}, 32'd0);
      check_eq("start_cond", start_seen - s0, 1);
      check_eq("start_lines", {30'd0, scl_oe, sda_oe}, 32'd3);

      sl_ack = 1'b1;
      r0 = rise_total;
      run_cmd(c_op_write, 8'hA5, 1, 1'b0, 1'b1, lat, e_seen);
      check_eq("wr_lat", lat, LAT_BYTE);
      check_eq("wr_err", {31'd0, e_seen}, 32'd0);
      check_eq("wr_rises", rise_total - r0, 9);
      check_eq("wr_bits_a5", {23'd0, rx_bits[8:0]}, {23'd0, 8'hA5, 1'b0});
      check_eq("wr_ack", {31'd0, ack_rx}, 32'd1);

      sl_ack = 1'b0;
      run_cmd(c_op_write, 8'h5A, 1, 1'b0, 1'b0, lat, e_seen);
      check_eq("wr_nack_bits", {23'd0, rx_bits[8:0]}, {23'd0, 8'h5A, 1'b1});
      check_eq("wr_nack_ack", {31'd0, ack_rx}, 32'd0);

      sl_byte = 8'h3C;
      run_cmd(c_op_read_nack, 8'h00, 2, 1'b0, 1'b0, lat, e_seen);
      check_eq("rdn_lat", lat, LAT_BYTE);
      check_eq("rdn_rdata", {24'd0, rdata}, 32'h3C);
      check_eq("rdn_line", {23'd0, rx_bits[8:0]}, {23'd0, 8'h3C, 1'b1});
      check_eq("rdn_ack_held", {31'd0, ack_rx}, 32'd0);

      sl_byte = 8'hC3;
      run_cmd(c_op_read_ack, 8'h00, 2, 1'b0, 1'b0, lat, e_seen);
      check_eq("rda_rdata", {24'd0, rdata}, 32'hC3);
      check_eq("rda_line", {23'd0, rx_bits[8:0]}, {23'd0, 8'hC3, 1'b0});

      scl_keep = scl_oe;
      sda_keep = sda_oe;
      run_cmd(3'd7, 8'h00, 0, 1'b0, 1'b0, lat, e_seen);
      check_eq("ill7_lat", lat, 1);
      check_eq("ill7_err", {31'd0, e_seen}, 32'd1);
      check_eq("ill7_lines", {30'd0, scl_oe, sda_oe}, {30'd0, scl_keep, sda_keep});
      check_eq("ill7_rdata", {24'd0, rdata}, 32'hC3);

      s0 = stop_seen;
      run_cmd(c_op_stop, 8'h00, 0, 1'b0, 1'b0, lat, e_seen);
      check_eq("stop_lat", lat, LAT_SHORT);
      check_eq("stop_err", {31'd0, e_seen}, 32'd0);
      check_eq("stop_cond", stop_seen - s0, 1);
      check_eq("stop_lines", {30'd0, scl_oe, sda_oe}, 32'd0);

      run_cmd(3'd0, 8'h00, 0, 1'b0, 1'b0, lat, e_seen);
      check_eq("ill0_err", {31'd0, e_seen}, 32'd1);
      check_eq("ill0_lines", {30'd0, scl_oe, sda_oe}, 32'd0);

      run_cmd(c_op_start, 8'h00, 0, 1'b0, 1'b0, lat, e_seen);
`ifdef I2C_CLK_STRETCH_EN
      sl_ack = 1'b1;
      run_cmd(c_op_write, 8'h96, 1, 1'b1, 1'b0, lat, e_seen);
      check_eq("str_bits", {23'd0, rx_bits[8:0]}, {23'd0, 8'h96, 1'b0});
      check_eq("str_ack", {31'd0, ack_rx}, 32'd1);
`else
      run_cmd(c_op_write, 8'h96, 0, 1'b1, 1'b0, lat, e_seen);
      check_eq("str_ack", {31'd0, ack_rx}, 32'd0);
`endif
      check_eq("str_lat", lat, LAT_BYTE + STRETCH_EXTRA);

      @(negedge clk);
      cmd_valid = 1'b1;
      cmd       = c_op_write;
      wdata     = 8'hFF;
      sl_mode   = 0;
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 1;
      while (lat < 67) begin
         @(negedge clk);
         lat++;
      end
      check_eq("abort_busy", {31'd0, cmd_ready}, 32'd0);
      nReset = 1'b0;
      @(negedge clk);
      check_eq("abort_lines", {30'd0, scl_oe, sda_oe}, 32'd0);
      check_eq("abort_ready", {31'd0, cmd_ready}, 32'd1);
      check_eq("abort_rsp", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      nReset = 1'b1;
      pulses = 0;
      repeat (200) begin
         @(negedge clk);
         if (rsp_valid) pulses++;
      end
      check_eq("abort_no_rsp", pulses, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no completion expected end of test");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/i2c_byte_master.md
I2C_BYTE_MASTER -- requirements
Module: i2c_byte_master

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 30, giving clk cycles per I2C quarter-bit (legal range 2..1023).
REQ-002 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-003 nReset  input  1  reset: synchronous, active-low.
REQ-004 cmd_valid  input  1  command request from the soft-core sequencer.
REQ-005 cmd  input  3  opcode: 1 START, 2 STOP, 3 WRITE, 4 READ_ACK, 5 READ_NACK; all other codes are illegal.
REQ-006 wdata  input  8  byte to transmit for WRITE.
REQ-007 cmd_ready  output  1  high only in IDLE; a command SHALL be accepted on a cycle with cmd_valid and cmd_ready both high.
REQ-008 rsp_valid  output  1  one-cycle completion pulse.
REQ-009 rdata  output  8  byte received by READ_*, held until the next READ completes.
REQ-010 ack_rx  output  1  1 = slave ACKed (SDA low on 9th bit of WRITE), held until the next WRITE completes.
REQ-011 err  output  1  qualifies rsp_valid; 1 = illegal opcode.
REQ-012 scl_oe, sda_oe  output  1 each  open-drain pull-low enables (1 = drive 0, 0 = release); tristate buffers are instantiated at chip top.
REQ-013 scl_in, sda_in  input  1 each  pad inputs, already synchronised by the instantiating level.

Function
REQ-014 A quarter tick SHALL occur every CLK_DIV clk cycles while not in IDLE; the tick counter SHALL restart at zero on command acceptance.
REQ-015 States SHALL be IDLE, START, STOP, WRITE, READ, DONE; every non-IDLE bit phase SHALL last exactly 4 quarters Q0..Q3.
REQ-016 START: Q0 release SDA; Q1 release SCL; Q2 pull SDA; Q3 pull SCL; also valid as repeated START with SCL low.
REQ-017 STOP: Q0 pull SDA; Q1 release SCL; Q2 release SDA; Q3 hold, both released.
REQ-018 Data bit: Q0 set SDA (SCL low); Q1 release SCL; Q2 sample sda_in; Q3 pull SCL.
REQ-019 WRITE SHALL send wdata MSB first (8 bits), then a 9th bit with SDA released; ack_rx SHALL be the inverse of the 9th-bit sample.
REQ-020 READ SHALL release SDA for 8 bits, shifting samples MSB first into rdata, then drive the 9th bit low for READ_ACK or release it for READ_NACK.
REQ-021 wdata SHALL be captured at acceptance; later changes SHALL have no effect.
REQ-022 Completion SHALL enter DONE for one cycle with rsp_valid=1, then IDLE with cmd_ready=1.
REQ-023 Total accept-to-rsp_valid latency SHALL be 4*CLK_DIV+1 cycles for START/STOP and 36*CLK_DIV+1 for WRITE/READ (no stretching).
REQ-024 An illegal opcode SHALL produce rsp_valid=1, err=1 on the cycle after acceptance, with lines unchanged.
REQ-025 In IDLE, scl_oe and sda_oe SHALL retain their last values, so SCL stays low between bytes of a transfer.

Reset
REQ-026 While nReset=0: state IDLE, scl_oe=0, sda_oe=0, cmd_ready=1, rsp_valid=0, err=0, rdata=0, ack_rx=0, tick counter 0.
REQ-027 Reset mid-operation SHALL abort immediately, releasing both lines on the next edge, with no STOP and no rsp_valid.

Configuration
REQ-028 With I2C_CLK_STRETCH_EN defined, the Q1->Q2 transition SHALL wait until scl_in=1 and the Q1 tick count SHALL restart when SCL is seen high.
REQ-029 Without I2C_CLK_STRETCH_EN, scl_in SHALL be ignored and timing SHALL be fixed per REQ-023.

Structure
REQ-030 Package i2c_pkg SHALL hold the opcode constants and the state enumeration, shared with the sequencer.
REQ-031 The quarter-tick divider SHALL be sub-module i2c_qtr_tick (inputs clk, nReset, run; output tick).

Verification
REQ-032 CLK_DIV=4: START then STOP -> SDA falls while SCL high, then SDA rises while SCL high; rsp_valid 17 cycles after each acceptance.
REQ-033 WRITE wdata=0xA5, slave model ACKs -> SDA bits 1,0,1,0,0,1,0,1 sampled on SCL high; ack_rx=1, err=0; repeat with NACK -> ack_rx=0.
REQ-034 READ_NACK, slave drives 0x3C -> rdata=0x3C, SDA released on 9th bit; READ_ACK -> 9th bit low.
REQ-035 cmd=7 -> rsp_valid and err high one cycle after acceptance, scl_oe/sda_oe unchanged; cmd_valid during WRITE -> not accepted (cmd_ready=0).
REQ-036 nReset low at bit 4 of a WRITE -> next cycle scl_oe=sda_oe=0, cmd_ready=1, no rsp_valid.
REQ-037 With I2C_CLK_STRETCH_EN, slave holds SCL low 50 cycles in bit 0 -> completion delayed by 50 cycles, data intact; without the macro -> latency unchanged.
